// File: rtl/write_port_demux.sv
// Steers each accepted (addr, data) write-back to one of WIDTH destinations via a one-hot select, with a forwarding lookup.
// Latency: a write accepted at edge n is presented on out_* from edge n. Forwarding is combinational from stored entries.
// Backpressure: a 2-entry FIFO absorbs out_ready stalls. The registered in_ready drops only while both entries are occupied.
module write_port_demux #(
   parameter int WIDTH    = 32,
   parameter int DATA_W   = 64,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [$clog2(WIDTH)-1:0] in_addr,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_sel,
   output logic [DATA_W-1:0]        out_data,
   input  logic [$clog2(WIDTH)-1:0] fwd_addr,
   output logic                     fwd_hit,
   output logic [DATA_W-1:0]        fwd_data
);

   localparam int AW = $clog2(WIDTH);
   localparam logic [AW-1:0] ZERO_ADDR = AW'(WIDTH - 1);

   // Two-entry storage. Occupancy is derived from count and rd_ptr, so no per-entry valid bits are needed.
   logic [AW-1:0]     addr_q [2];
   logic [DATA_W-1:0] data_q [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic              young_ptr;
   logic [1:0]        count;
   logic [1:0]        count_next;
   logic              in_ready_q;
   logic              accept;
   logic              enq;
   logic              deq;
   logic              zero_target;

   // A write to the hard-wired zero register completes its handshake but never occupies a slot.
   assign zero_target = (ZERO_REG != 0) && (in_addr == ZERO_ADDR);
   assign accept      = in_valid && in_ready_q;
   assign enq         = accept && !zero_target;
   assign deq         = out_valid && out_ready;
   assign in_ready    = in_ready_q;
   assign out_valid   = (count != 2'd0);
   assign out_data    = data_q[rd_ptr];
   assign young_ptr   = ~rd_ptr;

   // Occupancy after this edge. Enqueue and dequeue together leave the count unchanged.
   always_comb begin
      count_next = count;
      case ({enq, deq})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   // Decode the head destination. This is only ever a single bit, and it is cleared when nothing is pending.
   always_comb begin
      out_sel = '0;
      out_sel[addr_q[rd_ptr]] = out_valid;
   end

   // Forwarding lookup: check the head first, then let the younger entry override it so the newest data wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if ((count != 2'd0) && (addr_q[rd_ptr] == fwd_addr)) begin
         fwd_hit  = 1'b1;
         fwd_data = data_q[rd_ptr];
      end
      if ((count == 2'd2) && (addr_q[young_ptr] == fwd_addr)) begin
         fwd_hit  = 1'b1;
         fwd_data = data_q[young_ptr];
      end
   end

   // FIFO pointers, occupancy, entry storage and the registered in_ready.
   // in_ready is computed from next-state occupancy, so it is never a combinational function of out_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count      <= 2'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         in_ready_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         count      <= count_next;
         in_ready_q <= (count_next != 2'd2);
         if (enq) begin
            addr_q[wr_ptr] <= in_addr;
            data_q[wr_ptr] <= in_data;
            wr_ptr         <= ~wr_ptr;
         end
         if (deq) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

endmodule

// File: tb/tb_write_port_demux.sv
// Directed bench for write_port_demux (WIDTH=32, DATA_W=64, ZERO_REG=1).
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled before the next rising edge.
// Expected values are hand-derived constants for each directed vector.
module tb_write_port_demux;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_addr;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sel;
   logic [63:0] out_data;
   logic [4:0]  fwd_addr;
   logic        fwd_hit;
   logic [63:0] fwd_data;

   int n_cmp = 0;
   int n_err = 0;

   write_port_demux #(.WIDTH(32), .DATA_W(64), .ZERO_REG(1)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel),
      .out_data  (out_data),
      .fwd_addr  (fwd_addr),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then move 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_addr   = '0;
      in_data   = '0;
      out_ready = 1'b0;
      fwd_addr  = '0;

      // 1. reset for 3 cycles, then release
      repeat (3) tick();
      check_val("rst_in_ready",  64'(in_ready),  64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_out_sel",   64'(out_sel),   64'd0);
      check_val("rst_out_data",  out_data,       64'd0);
      check_val("rst_fwd_hit",   64'(fwd_hit),   64'd0);
      reset_n = 1'b1;
      #2;
      check_val("rel_in_ready_pre", 64'(in_ready), 64'd0);
      tick();
      check_val("rel_in_ready_post", 64'(in_ready),  64'd1);
      check_val("rel_out_valid",     64'(out_valid), 64'd0);
      check_val("rel_out_sel",       64'(out_sel),   64'd0);

      // 2. single write to address 5, consumed immediately
      in_valid = 1'b1; in_addr = 5'd5; in_data = 64'hABCD; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check_val("t2_out_valid", 64'(out_valid), 64'd1);
      check_val("t2_out_sel",   64'(out_sel),   64'h0000_0020);
      check_val("t2_out_data",  out_data,       64'hABCD);
      tick();
      check_val("t2_drained_valid", 64'(out_valid), 64'd0);
      check_val("t2_drained_sel",   64'(out_sel),   64'd0);

      // 3. two writes to address 3 while stalled, then forward and drain in order
      out_ready = 1'b0;
      in_valid = 1'b1; in_addr = 5'd3; in_data = 64'd1;
      tick();
      check_val("t3_ready_after1", 64'(in_ready), 64'd1);
      in_data = 64'd2;
      tick();
      in_valid = 1'b0;
      fwd_addr = 5'd3;
      #1;
      check_val("t3_ready_full", 64'(in_ready), 64'd0);
      check_val("t3_fwd_hit",    64'(fwd_hit),  64'd1);
      check_val("t3_fwd_data",   fwd_data,      64'd2);
      check_val("t3_head_sel",   64'(out_sel),  64'h8);
      check_val("t3_head_data",  out_data,      64'd1);
      out_ready = 1'b1;
      tick();
      check_val("t3_second_data",  out_data,       64'd2);
      check_val("t3_second_valid", 64'(out_valid), 64'd1);
      check_val("t3_ready_again",  64'(in_ready),  64'd1);
      check_val("t3_fwd_data_1",   fwd_data,       64'd2);
      tick();
      check_val("t3_empty", 64'(out_valid), 64'd0);
      out_ready = 1'b0;

      // 4. write to the zero register is accepted but discarded
      in_valid = 1'b1; in_addr = 5'd31; in_data = 64'h77;
      #1;
      check_val("t4_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      fwd_addr = 5'd31;
      #1;
      check_val("t4_out_valid", 64'(out_valid), 64'd0);
      check_val("t4_fwd_hit",   64'(fwd_hit),   64'd0);
      check_val("t4_in_ready",  64'(in_ready),  64'd1);

      // 5. streaming at count=1: prefill address 0, then addresses 1..7 with concurrent dequeue
      in_valid = 1'b1; in_addr = 5'd0; in_data = 64'h100;
      tick();
      out_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         in_addr  = 5'(i);
         in_data  = 64'h100 + 64'(i);
         fwd_addr = 5'(i - 1);
         #1;
         check_val($sformatf("t5_sel_%0d", i - 1),  64'(out_sel),   64'd1 << (i - 1));
         check_val($sformatf("t5_data_%0d", i - 1), out_data,       64'h100 + 64'(i - 1));
         check_val($sformatf("t5_rdy_%0d", i - 1),  64'(in_ready),  64'd1);
         check_val($sformatf("t5_fwd_%0d", i - 1),  fwd_data,       64'h100 + 64'(i - 1));
         tick();
      end
      in_valid = 1'b0;
      #1;
      check_val("t5_sel_7",  64'(out_sel), 64'd1 << 7);
      check_val("t5_data_7", out_data,     64'h107);
      tick();
      check_val("t5_empty", 64'(out_valid), 64'd0);

      // 6. fill with addresses 9 and 10, then apply async reset mid-cycle
      out_ready = 1'b0;
      in_valid = 1'b1; in_addr = 5'd9; in_data = 64'd9;
      tick();
      in_addr = 5'd10; in_data = 64'd10;
      tick();
      in_valid = 1'b0;
      fwd_addr = 5'd9;
      #1;
      check_val("t6_full_ready", 64'(in_ready), 64'd0);
      check_val("t6_full_valid", 64'(out_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      check_val("t6_rst_valid",    64'(out_valid), 64'd0);
      check_val("t6_rst_sel",      64'(out_sel),   64'd0);
      check_val("t6_rst_data",     out_data,       64'd0);
      check_val("t6_rst_fwd_hit",  64'(fwd_hit),   64'd0);
      check_val("t6_rst_fwd_data", fwd_data,       64'd0);
      check_val("t6_rst_ready",    64'(in_ready),  64'd0);
      tick();
      reset_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check_val("t6_rel_ready_pre", 64'(in_ready), 64'd0);
      for (int c = 0; c < 6; c++) begin
         tick();
         check_val($sformatf("t6_after_valid_%0d", c), 64'(out_valid), 64'd0);
         check_val($sformatf("t6_after_sel_%0d", c),   64'(out_sel),   64'd0);
      end
      check_val("t6_after_ready", 64'(in_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
